// File: rtl/instr_fetch_queue.sv
// Prefetching instruction fetch queue: issues sequential word fetches to a
// one-cycle-latency instruction memory and buffers {pc, word} pairs for the core.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clock,
    input  logic                     reset_n,
    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    input  logic [31:0]              mem_rdata,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [31:0]              instr_out,
    output logic [31:0]              instr_pc,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_req_pc;
    logic          r_inflight;
    logic          r_drop;
    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_wptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_fifo_pc   [DEPTH];
    logic [31:0]   r_fifo_word [DEPTH];
    logic          r_valid;
    logic [31:0]   r_out;
    logic [31:0]   r_pc;

    logic          w_credit;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_rptr_nxt;
    logic [CW-1:0] w_count_nxt;
    logic [31:0]   w_head_pc;
    logic [31:0]   w_head_word;
    logic [1:0]    w_unused_pc_lsb;

    assign w_unused_pc_lsb = redirect_pc[1:0];

    // Credit counts the outstanding response so a full queue can never overflow.
    assign w_credit    = ({1'b0, r_count} + {{CW{1'b0}}, r_inflight}) < (CW+1)'(DEPTH);
    assign w_issue     = ~redirect & w_credit;
    assign w_push      = r_inflight & ~r_drop & ~redirect;
    assign w_pop       = r_valid & instr_ready & ~redirect;
    assign w_rptr_nxt  = r_rptr + PW'(w_pop);
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    // When the next head is the entry being written this cycle, bypass the array.
    always_comb begin
        w_head_pc   = r_fifo_pc[w_rptr_nxt];
        w_head_word = r_fifo_word[w_rptr_nxt];
        if (w_push && (w_rptr_nxt == r_wptr)) begin
            w_head_pc   = r_req_pc;
            w_head_word = mem_rdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_pc <= RESET_PC;
            r_inflight <= 1'b0;
            r_drop     <= 1'b0;
            r_rptr     <= '0;
            r_wptr     <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_out      <= '0;
            r_pc       <= '0;
        end else if (redirect) begin
            r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            r_inflight <= 1'b0;
            r_drop     <= r_inflight;
            r_rptr     <= '0;
            r_wptr     <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_drop     <= 1'b0;
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            r_rptr  <= w_rptr_nxt;
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
            if (w_count_nxt != '0) begin
                r_out <= w_head_word;
                r_pc  <= w_head_pc;
            end
        end
    end

    // Datapath storage: only meaningful under the control state above.
    always_ff @(posedge clock) begin
        if (w_issue) begin
            r_req_pc <= r_fetch_pc;
        end
        if (w_push) begin
            r_fifo_pc[r_wptr]   <= r_req_pc;
            r_fifo_word[r_wptr] <= mem_rdata;
        end
    end

    assign mem_req     = reset_n & w_issue;
    assign mem_addr    = r_fetch_pc;
    assign instr_valid = r_valid;
    assign instr_out   = r_out;
    assign instr_pc    = r_pc;
    assign occupancy   = r_count;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue; memory returns word = address one cycle after each request.
module tb_instr_fetch_queue;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = 32'h0;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [2:0]  occupancy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .occupancy   (occupancy)
    );

    always @(posedge clock) mem_rdata <= mem_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   {31'b0, mem_req},     32'h0);
        check({tag, "_valid"}, {31'b0, instr_valid}, 32'h0);
        check({tag, "_occ"},   {29'b0, occupancy},   32'h0);
        check({tag, "_out"},   instr_out,            32'h0);
        check({tag, "_pc"},    instr_pc,             32'h0);
        check({tag, "_addr"},  mem_addr,             32'h0);
    endtask

    // Leaves the bench at the start of cycle 0 after release.
    task automatic do_reset();
        next_cycle();
        reset_n     = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        #1;
        check_reset_outputs("rst");
        @(posedge clock);
        @(posedge clock);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nreq;
        reset_n     = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        // Streaming with the core always ready.
        do_reset();
        instr_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) next_cycle();
            #1;
            check($sformatf("s_req%0d", k), {31'b0, mem_req}, 32'h1);
            check($sformatf("s_addr%0d", k), mem_addr, 32'(4 * k));
            check($sformatf("s_valid%0d", k), {31'b0, instr_valid}, (k >= 2) ? 32'h1 : 32'h0);
            if (k >= 2) begin
                check($sformatf("s_pc%0d", k), instr_pc, 32'(4 * (k - 2)));
                check($sformatf("s_out%0d", k), instr_out, 32'(4 * (k - 2)));
            end
        end

        // Core stalled for 10 cycles: queue fills to DEPTH and fetch stops.
        do_reset();
        instr_ready = 1'b0;
        nreq = 0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) next_cycle();
            #1;
            if (mem_req) nreq++;
        end
        check("stall_nreq", 32'(nreq), 32'd4);
        check("stall_occ", {29'b0, occupancy}, 32'd4);
        check("stall_req", {31'b0, mem_req}, 32'h0);
        next_cycle();
        instr_ready = 1'b1;
        #1;
        check("drain_req0", {31'b0, mem_req}, 32'h0);
        check("drain_valid0", {31'b0, instr_valid}, 32'h1);
        check("drain_pc0", instr_pc, 32'h0);
        for (int j = 1; j < 6; j++) begin
            next_cycle();
            #1;
            check($sformatf("drain_valid%0d", j), {31'b0, instr_valid}, 32'h1);
            check($sformatf("drain_pc%0d", j), instr_pc, 32'(4 * j));
            if (j == 1) begin
                check("resume_req", {31'b0, mem_req}, 32'h1);
                check("resume_addr", mem_addr, 32'h10);
            end
        end

        // Redirect with a pop and a push pending in the same cycle.
        do_reset();
        instr_ready = 1'b1;
        for (int k = 1; k < 3; k++) next_cycle();
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        #1;
        check("rd_req", {31'b0, mem_req}, 32'h0);
        check("rd_head_pc", instr_pc, 32'h4);
        next_cycle();
        redirect = 1'b0;
        #1;
        check("rd1_occ", {29'b0, occupancy}, 32'h0);
        check("rd1_valid", {31'b0, instr_valid}, 32'h0);
        check("rd1_req", {31'b0, mem_req}, 32'h1);
        check("rd1_addr", mem_addr, 32'h100);
        next_cycle();
        #1;
        check("rd2_valid", {31'b0, instr_valid}, 32'h0);
        check("rd2_occ", {29'b0, occupancy}, 32'h0);
        next_cycle();
        #1;
        check("rd3_valid", {31'b0, instr_valid}, 32'h1);
        check("rd3_pc", instr_pc, 32'h100);
        check("rd3_out", instr_out, 32'h100);
        next_cycle();
        #1;
        check("rd4_pc", instr_pc, 32'h104);

        // Redirect near the top of the address space: fetch PC wraps to zero.
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        #1;
        check("wr_req", {31'b0, mem_req}, 32'h0);
        next_cycle();
        redirect = 1'b0;
        #1;
        check("wr_addr1", mem_addr, 32'hFFFF_FFF8);
        next_cycle();
        #1;
        check("wr_addr2", mem_addr, 32'hFFFF_FFFC);
        next_cycle();
        #1;
        check("wr_addr3", mem_addr, 32'h0);
        check("wr_pc3", instr_pc, 32'hFFFF_FFF8);
        next_cycle();
        #1;
        check("wr_pc4", instr_pc, 32'hFFFF_FFFC);
        next_cycle();
        #1;
        check("wr_pc5", instr_pc, 32'h0);
        check("wr_out5", instr_out, 32'h0);

        // Back-to-back redirects: the second target wins.
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        next_cycle();
        redirect_pc = 32'h300;
        #1;
        check("bb_req", {31'b0, mem_req}, 32'h0);
        next_cycle();
        redirect = 1'b0;
        #1;
        check("bb_addr", mem_addr, 32'h300);
        check("bb_occ", {29'b0, occupancy}, 32'h0);
        next_cycle();
        #1;
        check("bb_valid1", {31'b0, instr_valid}, 32'h0);
        next_cycle();
        #1;
        check("bb_pc", instr_pc, 32'h300);

        // Asynchronous reset mid-stream with three entries held.
        do_reset();
        instr_ready = 1'b1;
        for (int k = 1; k < 4; k++) next_cycle();
        next_cycle();
        instr_ready = 1'b0;
        next_cycle();
        next_cycle();
        #1;
        check("mr_occ", {29'b0, occupancy}, 32'd3);
        check("mr_pc", instr_pc, 32'h8);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mr_rst");
        @(posedge clock);
        @(posedge clock);
        #2;
        reset_n     = 1'b1;
        instr_ready = 1'b1;
        #1;
        check("mr_req0", {31'b0, mem_req}, 32'h1);
        check("mr_addr0", mem_addr, 32'h0);
        next_cycle();
        #1;
        check("mr_valid1", {31'b0, instr_valid}, 32'h0);
        next_cycle();
        #1;
        check("mr_valid2", {31'b0, instr_valid}, 32'h1);
        check("mr_pc2", instr_pc, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
